// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the core's data-memory handshake.
// Accepts one load/store at a time, commits it to a word array on the
// acceptance edge and returns the response after latency_p cycles.
//
// Packed port layouts (MSB first):
//   mem_in_i  [35:0] = {write_data[31:0], valid, wen, byte_not_word, yumi}
//   mem_out_o [33:0] = {read_data[31:0], valid, yumi}
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   When defined, word accesses with addr[1:0] != 0 suppress the array write,
//   respond with 32'hDEADBEEF and set the sticky err_o flag.
//   When undefined, addr[1:0] is ignored for word accesses and err_o is 0.
module dmem_responder #(
  parameter int data_mem_addr_width_gp = 12,
  parameter int latency_p              = 2
) (
  input  logic                              clk,
  input  logic                              n_reset,
  input  logic [data_mem_addr_width_gp-1:0] addr_i,
  input  logic [35:0]                       mem_in_i,
  output logic [33:0]                       mem_out_o,
  output logic                              err_o
);

  localparam int         AW       = data_mem_addr_width_gp;
  localparam int         DEPTH    = 1 << (AW - 2);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY     = 2'd1;
  localparam logic [1:0] RESP     = 2'd2;
  localparam logic [3:0] LAT_LOAD = 4'(latency_p - 1);

  logic [31:0] in_wdata;
  logic        in_valid;
  logic        in_wen;
  logic        in_bnw;
  logic        in_yumi;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] resp_q, resp_d;
  logic [31:0] mem_q [DEPTH];

  logic [AW-3:0] word_idx;
  logic [1:0]    lane;
  logic          accept;
  logic          misalign;
  logic          commit;
  logic          resp_vld;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;

  assign {in_wdata, in_valid, in_wen, in_bnw, in_yumi} = mem_in_i;

  assign word_idx = addr_i[AW-1:2];
  assign lane     = addr_i[1:0];

  // Requests are only taken in IDLE; reset gating keeps yumi low and blocks
  // the (unreset) array from being written while reset is asserted.
  assign accept = n_reset & (state_q == IDLE) & in_valid;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ~in_bnw & (lane != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign commit  = accept & in_wen & ~misalign;
  assign rd_word = mem_q[word_idx];

  // Select the addressed byte lane (little-endian, lane 0 = bits 7:0).
  always_comb begin
    rd_byte = rd_word[7:0];
    case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  // Response value captured at acceptance: trap pattern, zero for stores,
  // zero-extended byte for LBU, full word otherwise.
  always_comb begin
    resp_d = 32'h0;
    if (misalign) begin
      resp_d = 32'hDEADBEEF;
    end else if (!in_wen) begin
      resp_d = in_bnw ? {24'h0, rd_byte} : rd_word;
    end
  end

  // Next-state and latency counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = LAT_LOAD;
          state_d = (latency_p == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (in_yumi) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control state: asynchronous reset aborts any request in flight.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response data register; only observable through the RESP gate below.
  always_ff @(posedge clk) begin
    if (accept) begin
      resp_q <= resp_d;
    end
  end

  // Array write on the acceptance edge: whole word or a single byte lane.
  always_ff @(posedge clk) begin
    if (commit) begin
      if (in_bnw) begin
        case (lane)
          2'd0:    mem_q[word_idx][7:0]   <= in_wdata[7:0];
          2'd1:    mem_q[word_idx][15:8]  <= in_wdata[7:0];
          2'd2:    mem_q[word_idx][23:16] <= in_wdata[7:0];
          default: mem_q[word_idx][31:24] <= in_wdata[7:0];
        endcase
      end else begin
        mem_q[word_idx] <= in_wdata;
      end
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      err_q <= 1'b0;
    end else if (accept && misalign) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // read_data is forced to zero whenever no response is presented.
  assign resp_vld  = (state_q == RESP);
  assign mem_out_o = {(resp_vld ? resp_q : 32'h0), resp_vld, accept};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with latency 2 and one
// with latency 1 sharing clock and reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [11:0] addr0, addr1;
  logic [35:0] min0, min1;
  logic [33:0] mout0, mout1;
  logic        err0, err1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.data_mem_addr_width_gp(12), .latency_p(2)) u_dut_l2 (
    .clk(clk), .n_reset(n_reset), .addr_i(addr0), .mem_in_i(min0),
    .mem_out_o(mout0), .err_o(err0)
  );

  dmem_responder #(.data_mem_addr_width_gp(12), .latency_p(1)) u_dut_l1 (
    .clk(clk), .n_reset(n_reset), .addr_i(addr1), .mem_in_i(min1),
    .mem_out_o(mout1), .err_o(err1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] req(input logic [31:0] wd, input logic v,
                                      input logic wen, input logic bnw, input logic y);
    return {wd, v, wen, bnw, y};
  endfunction

  function automatic logic [33:0] mout(input bit s);
    return s ? mout1 : mout0;
  endfunction

  task automatic drive(input bit s, input logic [11:0] a, input logic [35:0] m);
    if (s) begin
      addr1 = a;
      min1  = m;
    end else begin
      addr0 = a;
      min0  = m;
    end
  endtask

  // Called just after the acceptance edge; waits (bounded) for valid.
  task automatic wait_resp(input bit s, input string tag, input logic [31:0] exp_rd);
    logic [33:0] o;
    int k;
    int lat;
    lat = s ? 1 : 2;
    k = 0;
    o = mout(s);
    while (!o[1] && k < 20) begin
      @(posedge clk); #1;
      k++;
      o = mout(s);
    end
    check_eq({tag, "_lat"}, 32'(k), 32'(lat - 1));
    check_eq({tag, "_rd"}, o[33:2], exp_rd);
  endtask

  task automatic consume(input bit s, input string tag);
    logic [33:0] o;
    drive(s, 12'h0, req(32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    @(posedge clk); #1;
    drive(s, 12'h0, req(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    o = mout(s);
    check_eq({tag, "_vld0"}, {31'h0, o[1]}, 32'h0);
    check_eq({tag, "_rd0"}, o[33:2], 32'h0);
  endtask

  task automatic xact(input bit s, input string tag, input logic [11:0] a, input logic wen,
                      input logic bnw, input logic [31:0] wd, input logic [31:0] exp_rd);
    logic [33:0] o;
    drive(s, a, req(wd, 1'b1, wen, bnw, 1'b0));
    #1;
    o = mout(s);
    check_eq({tag, "_ack"}, {31'h0, o[0]}, 32'h1);
    @(posedge clk); #1;
    drive(s, a, req(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_resp(s, tag, exp_rd);
    consume(s, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    n_reset = 1'b1;
    addr0 = 12'h0; addr1 = 12'h0;
    min0 = 36'h0;  min1 = 36'h0;

    // Reset values
    #2 n_reset = 1'b0;
    #1;
    check_eq("rst_rd0", mout0[33:2], 32'h0);
    check_eq("rst_flags0", {30'h0, mout0[1:0]}, 32'h0);
    check_eq("rst_rd1", mout1[33:2], 32'h0);
    check_eq("rst_err", {30'h0, err0, err1}, 32'h0);
    // yumi must stay low while reset is held even with a request present
    drive(0, 12'h010, req(32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
    #1;
    check_eq("rst_ack_gated", {31'h0, mout0[0]}, 32'h0);
    drive(0, 12'h0, 36'h0);
    repeat (2) @(posedge clk);
    #3 n_reset = 1'b1;
    @(posedge clk); #1;

    // Basic word store/load, byte store, byte load
    xact(0, "sw10",  12'h010, 1'b1, 1'b0, 32'h12345678, 32'h0);
    xact(0, "lw10",  12'h010, 1'b0, 1'b0, 32'h0, 32'h12345678);
    xact(0, "sb13",  12'h013, 1'b1, 1'b1, 32'h000000AB, 32'h0);
    xact(0, "lw10b", 12'h010, 1'b0, 1'b0, 32'h0, 32'hAB345678);
    xact(0, "lbu12", 12'h012, 1'b0, 1'b1, 32'h0, 32'h00000034);

    // Response hold while yumi is withheld and a new request is pending
    drive(0, 12'h010, req(32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    drive(0, 12'h013, req(32'h0, 1'b1, 1'b0, 1'b1, 1'b0));
    wait_resp(0, "hold", 32'hAB345678);
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_rd", mout0[33:2], 32'hAB345678);
      check_eq("hold_ack", {31'h0, mout0[0]}, 32'h0);
      @(posedge clk); #1;
    end
    check_eq("hold_vld", {31'h0, mout0[1]}, 32'h1);
    drive(0, 12'h013, req(32'h0, 1'b1, 1'b0, 1'b1, 1'b1));
    @(posedge clk); #1;
    drive(0, 12'h013, req(32'h0, 1'b1, 1'b0, 1'b1, 1'b0));
    #1;
    check_eq("hold_idle_vld", {31'h0, mout0[1]}, 32'h0);
    check_eq("hold_idle_ack", {31'h0, mout0[0]}, 32'h1);
    @(posedge clk); #1;
    drive(0, 12'h0, 36'h0);
    wait_resp(0, "hold_next", 32'h000000AB);
    consume(0, "hold_next");

    // Latency 1: preload four words, then loads with yumi held high
    for (int i = 0; i < 4; i++) begin
      xact(1, "l1_sw", 12'(i * 4), 1'b1, 1'b0, 32'hA0A00000 + 32'(i), 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 12'(i * 4), req(32'h0, 1'b1, 1'b0, 1'b0, 1'b1));
      #1;
      check_eq("l1_ack", {31'h0, mout1[0]}, 32'h1);
      @(posedge clk); #1;
      drive(1, 12'h0, req(32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
      check_eq("l1_vld", {31'h0, mout1[1]}, 32'h1);
      check_eq("l1_rd", mout1[33:2], 32'hA0A00000 + 32'(i));
      @(posedge clk); #1;
      check_eq("l1_idle", {30'h0, mout1[1:0]}, 32'h0);
      @(posedge clk); #1;
    end
    drive(1, 12'h0, 36'h0);

    // Reset in RESP drops the response without a clock edge
    drive(0, 12'h010, req(32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    drive(0, 12'h0, 36'h0);
    wait_resp(0, "rst_resp", 32'hAB345678);
    #2 n_reset = 1'b0;
    #1;
    check_eq("rst_resp_rd", mout0[33:2], 32'h0);
    check_eq("rst_resp_flags", {30'h0, mout0[1:0]}, 32'h0);
    @(posedge clk);
    #3 n_reset = 1'b1;
    @(posedge clk); #1;

    // Reset in BUSY after an accepted store; the store must survive
    drive(0, 12'h020, req(32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0));
    @(posedge clk); #1;
    drive(0, 12'h0, 36'h0);
    #2 n_reset = 1'b0;
    #1;
    check_eq("rst_busy_out", {30'h0, mout0[1:0]}, 32'h0);
    @(posedge clk);
    #3 n_reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_busy_novld", {31'h0, mout0[1]}, 32'h0);
    xact(0, "lw20", 12'h020, 1'b0, 1'b0, 32'h0, 32'hCAFEF00D);

    // Misaligned word accesses
`ifdef DMEM_MISALIGN_TRAP_EN
    check_eq("err_pre", {31'h0, err0}, 32'h0);
    xact(0, "lw11", 12'h011, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF);
    check_eq("err_set", {31'h0, err0}, 32'h1);
    xact(0, "sw11", 12'h011, 1'b1, 1'b0, 32'h11111111, 32'hDEADBEEF);
    xact(0, "lw10c", 12'h010, 1'b0, 1'b0, 32'h0, 32'hAB345678);
    check_eq("err_sticky", {31'h0, err0}, 32'h1);
`else
    xact(0, "lw11", 12'h011, 1'b0, 1'b0, 32'h0, 32'hAB345678);
    check_eq("err_off", {31'h0, err0}, 32'h0);
    xact(0, "sw11", 12'h011, 1'b1, 1'b0, 32'h11111111, 32'h0);
    xact(0, "lw10c", 12'h010, 1'b0, 1'b0, 32'h0, 32'h11111111);
    check_eq("err_off2", {31'h0, err0}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
